// File: rtl/status_pkg.sv
// Shared definitions for the status banner: event codes, sprite codes, FSM states
// and the on-screen banner rectangle.
package status_pkg;

  typedef enum logic [2:0] {
    EvtNewGame    = 3'd0,
    EvtWhiteMoved = 3'd1,
    EvtBlackMoved = 3'd2,
    EvtCheck      = 3'd3,
    EvtMate       = 3'd4,
    EvtStalemate  = 3'd5
  } evt_code_e;

  typedef enum logic [1:0] {
    SprWToPlay   = 2'd0,
    SprBToPlay   = 2'd1,
    SprCheckmate = 2'd2,
    SprStalemate = 2'd3
  } sprite_e;

  typedef enum logic [1:0] {
    StPlay,
    StCheck,
    StMate,
    StStale
  } state_e;

  // Banner occupies 560 < x <= 639, 434 <= y < 479
  localparam logic [9:0] BannerXMin = 10'd560;
  localparam logic [9:0] BannerXMax = 10'd639;
  localparam logic [9:0] BannerYMin = 10'd434;
  localparam logic [9:0] BannerYMax = 10'd479;

  // First pixel after the visible area; seen exactly once per frame
  localparam logic [9:0] TickX = 10'd0;
  localparam logic [9:0] TickY = 10'd480;

  function automatic sprite_e side_sprite(input logic side);
    return side ? SprBToPlay : SprWToPlay;
  endfunction

endpackage

// File: rtl/status_banner_ctrl_if.sv
// Event handshake from the game engine into the status banner controller.
interface status_banner_ctrl_if;
  logic       evt_valid;
  logic [2:0] evt_code;
  logic       evt_ready;

  modport master (output evt_valid, output evt_code, input evt_ready);
  modport slave  (input evt_valid, input evt_code, output evt_ready);
endinterface

// File: rtl/frame_blink_counter.sv
// Counts frames while the banner is in check and toggles visibility every
// BLINK_FRAMES frames; clear forces the counter to 0 and the banner visible.
module frame_blink_counter #(
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_tick,
  input  logic clear,
  output logic visible
);

  localparam int unsigned CntW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(BLINK_FRAMES - 1);

  logic [CntW-1:0] cnt_q;
  logic            visible_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      visible_q <= 1'b1;
    end else if (clear) begin
      cnt_q     <= '0;
      visible_q <= 1'b1;
    end else if (frame_tick) begin
      if (cnt_q == CntMax) begin
        cnt_q     <= '0;
        visible_q <= ~visible_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign visible = visible_q;

endmodule

// File: rtl/status_banner_ctrl.sv
// Status banner controller: buffers one game event, applies it at the frame
// boundary so the banner never changes mid-frame, and selects the banner sprite.
module status_banner_ctrl
  import status_pkg::*;
#(
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic                       vga_clk,
  input  logic                       reset,
  input  logic [9:0]                 DrawX,
  input  logic [9:0]                 DrawY,
  status_banner_ctrl_if.slave        evt,
  output logic [1:0]                 sprite_sel,
  output logic                       banner_on
);

  state_e     state_q;
  logic       side_q;
  sprite_e    sprite_sel_q;
  logic       pend_valid_q;
  logic [2:0] pend_code_q;

  logic frame_tick;
  logic accept;
  logic commit;
  logic in_play;
  logic cmd_acts;
  logic blink_clear;
  logic visible;

  assign frame_tick = (DrawX == TickX) && (DrawY == TickY);
  assign accept     = evt.evt_valid && !pend_valid_q;
  assign commit     = frame_tick && pend_valid_q;
  assign in_play    = (state_q == StPlay) || (state_q == StCheck);

  // A committed event that actually changes game state (not an ignored code)
  assign cmd_acts = commit && ((pend_code_q == EvtNewGame) ||
                               (in_play && (pend_code_q <= EvtStalemate)));

  // Blink only runs while sitting in check; any acting event restarts it
  assign blink_clear = (state_q != StCheck) || cmd_acts;

  assign evt.evt_ready = !pend_valid_q;

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state_q      <= StPlay;
      side_q       <= 1'b0;
      sprite_sel_q <= SprWToPlay;
      pend_valid_q <= 1'b0;
      pend_code_q  <= 3'd0;
    end else if (accept) begin
      pend_valid_q <= 1'b1;
      pend_code_q  <= evt.evt_code;
    end else if (commit) begin
      pend_valid_q <= 1'b0;
      if (pend_code_q == EvtNewGame) begin
        state_q      <= StPlay;
        side_q       <= 1'b0;
        sprite_sel_q <= SprWToPlay;
      end else if (in_play) begin
        case (pend_code_q)
          EvtWhiteMoved: begin
            state_q      <= StPlay;
            side_q       <= 1'b1;
            sprite_sel_q <= SprBToPlay;
          end
          EvtBlackMoved: begin
            state_q      <= StPlay;
            side_q       <= 1'b0;
            sprite_sel_q <= SprWToPlay;
          end
          EvtCheck: begin
            state_q      <= StCheck;
            sprite_sel_q <= side_sprite(side_q);
          end
          EvtMate: begin
            state_q      <= StMate;
            sprite_sel_q <= SprCheckmate;
          end
          EvtStalemate: begin
            state_q      <= StStale;
            sprite_sel_q <= SprStalemate;
          end
          default: ;
        endcase
      end
    end
  end

  frame_blink_counter #(
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_blink (
    .clk        (vga_clk),
    .rst        (reset),
    .frame_tick (frame_tick),
    .clear      (blink_clear),
    .visible    (visible)
  );

  assign sprite_sel = sprite_sel_q;
  assign banner_on  = visible &&
                      (DrawX > BannerXMin) && (DrawX <= BannerXMax) &&
                      (DrawY >= BannerYMin) && (DrawY < BannerYMax);

endmodule

// File: tb/tb_status_banner_ctrl.sv
// Bench for status_banner_ctrl: table of events with scoreboarded sprite results,
// plus hand-written reset, frame-boundary and blink sequences.
module tb_status_banner_ctrl;
  import status_pkg::*;

  logic       vga_clk = 1'b0;
  logic       reset   = 1'b1;
  logic [9:0] DrawX   = 10'd0;
  logic [9:0] DrawY   = 10'd0;
  logic [1:0] sprite_sel;
  logic       banner_on;

  status_banner_ctrl_if evt_if ();

  status_banner_ctrl #(
    .BLINK_FRAMES (2)
  ) dut (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .evt        (evt_if),
    .sprite_sel (sprite_sel),
    .banner_on  (banner_on)
  );

  always #5 vga_clk = ~vga_clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [1:0] exp_q[$];

  typedef struct {
    logic [2:0] code;
    logic [1:0] sprite;
  } vec_t;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       on;
  } pix_t;

  vec_t vecs[15];
  pix_t pixs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clk_step();
    @(posedge vga_clk);
    #1;
  endtask

  // Offer one event at pixel (x,y); waits a bounded number of cycles for ready
  task automatic offer(input logic [2:0] code, input logic [9:0] x, input logic [9:0] y);
    DrawX = x;
    DrawY = y;
    evt_if.evt_valid = 1'b1;
    evt_if.evt_code  = code;
    for (int i = 0; i < 4 && !evt_if.evt_ready; i++) clk_step();
    chk("offer_ready", evt_if.evt_ready, 1);
    clk_step();
    evt_if.evt_valid = 1'b0;
  endtask

  task automatic frame();
    DrawX = 10'd0;
    DrawY = 10'd480;
    clk_step();
    DrawX = 10'd1;
  endtask

  task automatic pop_chk(input string name);
    logic [1:0] e;
    if (exp_q.size() == 0) begin
      chk({name, "_sb_empty"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk(name, sprite_sel, e);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] cur;
    logic       blink_exp[6];

    vecs[0]  = '{EvtWhiteMoved, 2'd1};
    vecs[1]  = '{EvtBlackMoved, 2'd0};
    vecs[2]  = '{EvtCheck,      2'd0};
    vecs[3]  = '{EvtWhiteMoved, 2'd1};
    vecs[4]  = '{EvtCheck,      2'd1};
    vecs[5]  = '{3'd6,          2'd1};
    vecs[6]  = '{EvtStalemate,  2'd3};
    vecs[7]  = '{EvtWhiteMoved, 2'd3};
    vecs[8]  = '{EvtCheck,      2'd3};
    vecs[9]  = '{EvtNewGame,    2'd0};
    vecs[10] = '{EvtMate,       2'd2};
    vecs[11] = '{EvtBlackMoved, 2'd2};
    vecs[12] = '{3'd7,          2'd2};
    vecs[13] = '{EvtNewGame,    2'd0};
    vecs[14] = '{3'd7,          2'd0};

    pixs[0] = '{10'd600, 10'd450, 1'b1};
    pixs[1] = '{10'd560, 10'd450, 1'b0};
    pixs[2] = '{10'd561, 10'd434, 1'b1};
    pixs[3] = '{10'd639, 10'd478, 1'b1};
    pixs[4] = '{10'd640, 10'd450, 1'b0};
    pixs[5] = '{10'd600, 10'd433, 1'b0};
    pixs[6] = '{10'd600, 10'd479, 1'b0};

    blink_exp[0] = 1'b1; blink_exp[1] = 1'b1;
    blink_exp[2] = 1'b0; blink_exp[3] = 1'b0;
    blink_exp[4] = 1'b1; blink_exp[5] = 1'b1;

    evt_if.evt_valid = 1'b0;
    evt_if.evt_code  = 3'd0;

    // Reset state
    repeat (3) clk_step();
    chk("rst_sprite", sprite_sel, 0);
    chk("rst_ready", evt_if.evt_ready, 1);
    reset = 1'b0;
    clk_step();

    // Mid-frame reset discards a pending event
    offer(EvtWhiteMoved, 10'd100, 10'd10);
    frame();
    chk("pre_rst_sprite", sprite_sel, 1);
    offer(EvtBlackMoved, 10'd300, 10'd200);
    chk("pre_rst_pending", evt_if.evt_ready, 0);
    DrawX = 10'd301;
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_sprite", sprite_sel, 0);
    chk("async_rst_ready", evt_if.evt_ready, 1);
    clk_step();
    reset = 1'b0;
    foreach (pixs[i]) begin
      DrawX = pixs[i].x;
      DrawY = pixs[i].y;
      #1;
      chk($sformatf("banner_%0d_%0d", pixs[i].x, pixs[i].y), banner_on, pixs[i].on);
    end
    frame();
    chk("rst_discard_sprite", sprite_sel, 0);
    chk("rst_discard_ready", evt_if.evt_ready, 1);

    // Table of events: each deferred to the next frame_tick
    cur = 2'd0;
    foreach (vecs[i]) begin
      offer(vecs[i].code, 10'd100, 10'd10);
      exp_q.push_back(vecs[i].sprite);
      chk($sformatf("vec%0d_busy", i), evt_if.evt_ready, 0);
      chk($sformatf("vec%0d_held", i), sprite_sel, cur);
      DrawX = 10'd0;
      DrawY = 10'd479;
      clk_step();
      chk($sformatf("vec%0d_held_479", i), sprite_sel, cur);
      frame();
      pop_chk($sformatf("vec%0d_sprite", i));
      cur = vecs[i].sprite;
      chk($sformatf("vec%0d_ready", i), evt_if.evt_ready, 1);
      DrawX = 10'd600;
      DrawY = 10'd450;
      #1;
      chk($sformatf("vec%0d_banner", i), banner_on, 1);
    end

    // Event offered on the frame_tick cycle waits a full frame
    offer(EvtWhiteMoved, 10'd0, 10'd480);
    exp_q.push_back(2'd1);
    chk("tick_accept_busy", evt_if.evt_ready, 0);
    chk("tick_accept_held", sprite_sel, 0);
    DrawX = 10'd5;
    repeat (3) clk_step();
    chk("tick_accept_held2", sprite_sel, 0);
    frame();
    pop_chk("tick_accept_sprite");
    chk("tick_accept_ready", evt_if.evt_ready, 1);

    // Reserved code consumed with no visible change
    offer(3'd7, 10'd50, 10'd50);
    chk("rsv_busy", evt_if.evt_ready, 0);
    frame();
    chk("rsv_sprite", sprite_sel, 1);
    chk("rsv_ready", evt_if.evt_ready, 1);

    // Blink: two frames on, two off
    offer(EvtCheck, 10'd100, 10'd10);
    frame();
    chk("check_sprite", sprite_sel, 1);
    for (int k = 0; k < 6; k++) begin
      DrawX = 10'd600;
      DrawY = 10'd450;
      #1;
      chk($sformatf("blink_frame%0d", k), banner_on, blink_exp[k]);
      frame();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/status_banner_ctrl.md
STATUS_BANNER_CTRL -- requirements
Module: status_banner_ctrl

Interface
REQ-001 SHALL have parameter BLINK_FRAMES, default 30, frames per blink half-period.
REQ-002 SHALL have port vga_clk  input  1  pixel clock, the single clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port DrawX  input  10  current pixel column.
REQ-005 SHALL have port DrawY  input  10  current pixel row.
REQ-006 SHALL have port evt_valid  input  1  game-engine event offered.
REQ-007 SHALL have port evt_code  input  3  event code: 0 NEW_GAME, 1 WHITE_MOVED, 2 BLACK_MOVED, 3 CHECK, 4 MATE, 5 STALEMATE, 6-7 reserved.
REQ-008 SHALL have port evt_ready  output  1  event slot free.
REQ-009 SHALL have port sprite_sel  output  2  banner sprite: 0 W_TO_PLAY, 1 B_TO_PLAY, 2 CHECKMATE, 3 STALEMATE.
REQ-010 SHALL have port banner_on  output  1  current pixel lies in the drawn banner.

Function
REQ-011 SHALL hold one pending-event register; evt_ready = not pend_valid; event accepted on evt_valid and evt_ready at the clock edge.
REQ-012 SHALL define frame_tick = (DrawX == 0 and DrawY == 480), true exactly one cycle per frame.
REQ-013 SHALL commit the pending event only on a frame_tick edge; outputs reflect it from the next cycle; pend_valid clears on the same edge.
REQ-014 SHALL not commit an event accepted on a frame_tick edge until the following frame_tick.
REQ-015 SHALL implement FSM states PLAY, CHECK, MATE, STALE, plus side register (0 white, 1 black).
REQ-016 SHALL, on NEW_GAME from any state: state PLAY, side white, banner visible.
REQ-017 SHALL, in PLAY or CHECK, on WHITE_MOVED: side black, state PLAY; on BLACK_MOVED: side white, state PLAY.
REQ-018 SHALL, in PLAY or CHECK, on CHECK: state CHECK, side unchanged, blink counter 0, banner visible.
REQ-019 SHALL, in PLAY or CHECK, on MATE: state MATE; on STALEMATE: state STALE.
REQ-020 SHALL, in MATE or STALE, consume and ignore all codes except NEW_GAME.
REQ-021 SHALL consume and ignore reserved codes 6-7 in every state.
REQ-022 SHALL drive sprite_sel = side in PLAY/CHECK, 2 in MATE, 3 in STALE.
REQ-023 SHALL, in CHECK, count frame_ticks 0..BLINK_FRAMES-1 (counter width ceil(log2(BLINK_FRAMES))), toggling visibility and wrapping to 0 at BLINK_FRAMES-1.
REQ-024 SHALL keep the banner visible and the counter at 0 in PLAY, MATE, STALE.
REQ-025 SHALL drive banner_on combinationally = visible and 560 < DrawX <= 639 and 434 <= DrawY < 479.

Reset
REQ-026 SHALL, while reset is high, asynchronously force state PLAY, side white, visible 1, counter 0, pend_valid 0.
REQ-027 SHALL therefore present sprite_sel 0 and evt_ready 1 during and after reset; a pending event is discarded if reset occurs mid-operation.

Structure
REQ-028 SHALL take event codes, sprite_sel codes, FSM state enum and banner region bounds (560, 639, 434, 479) from shared package status_pkg.
REQ-029 SHALL contain one sub-module, frame_blink_counter, holding the frame-tick counter and visibility toggle.
REQ-030 SHALL feed sprite_sel and banner_on to the existing banner sprite ROM/palette path; no ROM access inside this block.

Verification
REQ-031 SHALL test reset: assert reset mid-frame -> sprite_sel 0, evt_ready 1, banner_on 1 at (600,450), 0 at (560,450).
REQ-032 SHALL test deferral: WHITE_MOVED accepted at (100,10) -> evt_ready 0, sprite_sel stays 0 until cycle after (0,480), then 1, evt_ready 1.
REQ-033 SHALL test blink: BLINK_FRAMES=2, CHECK committed -> banner_on at (600,450) visible frames 0-1, hidden frames 2-3, visible frames 4-5.
REQ-034 SHALL test game over: MATE committed -> sprite_sel 2; then BLACK_MOVED consumed, sprite_sel still 2; NEW_GAME -> sprite_sel 0.
REQ-035 SHALL test boundary: event offered exactly on frame_tick cycle -> committed one frame later; reserved code 7 -> consumed, no output change.
